// File: rtl/dump_record_fifo.sv
// rtl/dump_record_fifo.sv - record FIFO for channel-0 correlator dumps, drained over wishbone
//
// Purpose: each dump pulse captures one record of W 32-bit words in a single
// wide write. Firmware pops the head record one word at a time through the
// DATA register. A level interrupt reports that the fill level has reached the
// programmed watermark.
//
// Optional feature: define DUMP_FIFO_TIMESTAMP_EN to add a fifth word
// {8'h0, accum_count} to every record (W=5). When it is not defined, W=4 and
// accum_count is unused.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   dump                      one-cycle capture pulse
//   i_/q_early/prompt/late    16-bit correlator accumulations
//   epoch                     11-bit epoch counter
//   accum_count               24-bit time-base count (timestamp build only)
//   wb_adr_i .. wb_ack_o      wishbone slave (regs at adr[3:2]: DATA, STATUS, CONTROL, reserved)
//   irq                       registered level interrupt, count >= watermark (watermark != 0)
module dump_record_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dump,
    input  logic [15:0] i_early,
    input  logic [15:0] q_early,
    input  logic [15:0] i_prompt,
    input  logic [15:0] q_prompt,
    input  logic [15:0] i_late,
    input  logic [15:0] q_late,
    input  logic [10:0] epoch,
    input  logic [23:0] accum_count,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);
`ifdef DUMP_FIFO_TIMESTAMP_EN
    localparam int W = 5;
`else
    localparam int W = 4;
`endif
    localparam int RW = 32 * W;

    logic [RW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [2:0]    r_rd_word;
    logic          r_overflow;
    logic [5:0]    r_drops;
    logic [7:0]    r_watermark;
    logic          r_ack;
    logic [31:0]   r_dat;
    logic          r_irq;

    logic [RW-1:0] w_rec;
    logic [RW-1:0] w_head;
    logic [31:0]   w_head_word;
    logic [31:0]   w_rd_mux;
    logic [8:0]    w_count_ext;
    logic [AW:0]   w_count_nxt;
    logic [7:0]    w_wm_nxt;
    logic          w_access;
    logic          w_rd_data;
    logic          w_wr_ctrl;
    logic          w_flush;
    logic          w_clr;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_unused;

    // Word 0 sits in the least significant 32 bits of the record.
`ifdef DUMP_FIFO_TIMESTAMP_EN
    assign w_rec = {{8'h0, accum_count}, {21'h0, epoch}, {i_late, q_late},
                    {i_prompt, q_prompt}, {i_early, q_early}};
    assign w_unused = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:10], w_count_ext[8]};
`else
    assign w_rec = {{21'h0, epoch}, {i_late, q_late}, {i_prompt, q_prompt}, {i_early, q_early}};
    assign w_unused = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:10], w_count_ext[8],
                        accum_count};
`endif

    // An access is taken only while ack is low, so every access gets one idle cycle after it.
    assign w_access  = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_rd_data = w_access & ~wb_we_i & (wb_adr_i[3:2] == 2'd0);
    assign w_wr_ctrl = w_access & wb_we_i & (wb_adr_i[3:2] == 2'd2);
    assign w_flush   = w_wr_ctrl & wb_dat_i[8];
    assign w_clr     = w_wr_ctrl & wb_dat_i[9];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_pop     = w_rd_data & ~w_empty & (r_rd_word == 3'(W - 1));
    // A record-completing pop frees a slot in the same cycle, so a dump is never lost then.
    assign w_push    = dump & ~w_flush & (~w_full | w_pop);
    assign w_drop    = dump & ~w_flush & w_full & ~w_pop;
    assign w_count_ext = 9'(r_count);
    assign w_wm_nxt  = w_wr_ctrl ? wb_dat_i[7:0] : r_watermark;

    always_comb begin
        w_head      = r_mem[r_rd_ptr];
        w_head_word = 32'h0;
        for (int k = 0; k < W; k++) begin
            if (r_rd_word == 3'(k)) begin
                w_head_word = w_head[32*k +: 32];
            end
        end
    end

    always_comb begin
        w_rd_mux = 32'h0;
        case (wb_adr_i[3:2])
            2'd0:    w_rd_mux = w_empty ? 32'h0 : w_head_word;
            2'd1:    w_rd_mux = {16'h0, w_count_ext[7:0], r_drops, r_overflow, w_empty};
            2'd2:    w_rd_mux = {24'h0, r_watermark};
            default: w_rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_word   <= '0;
            r_overflow  <= 1'b0;
            r_drops     <= '0;
            r_watermark <= '0;
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_ack <= w_access;
            if (w_access) begin
                r_dat <= wb_we_i ? 32'h0 : w_rd_mux;
            end
            r_watermark <= w_wm_nxt;
            r_count     <= w_count_nxt;
            r_irq       <= (w_wm_nxt != 8'h0) && (9'(w_count_nxt) >= 9'(w_wm_nxt));

            if (w_flush) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_rd_word <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_rd_data && !w_empty) begin
                    if (w_pop) begin
                        r_rd_ptr  <= r_rd_ptr + 1'b1;
                        r_rd_word <= '0;
                    end else begin
                        r_rd_word <= r_rd_word + 1'b1;
                    end
                end
            end

            if (w_clr) begin
                r_overflow <= 1'b0;
                r_drops    <= '0;
            end
            // A drop in the same cycle as a clear is still recorded.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (w_clr) begin
                    r_drops <= 6'd1;
                end else if (r_drops != 6'd63) begin
                    r_drops <= r_drops + 1'b1;
                end
            end
        end
    end

    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign irq      = r_irq;
endmodule
